// File: rtl/svfloat_norm_seq.sv
// Sequential normalizer: scans the operand one chunk per cycle from the top,
// then left-justifies it and reports the shift amount and an all-zero flag.
module svfloat_norm_seq #(
  parameter int width = 32,
  parameter int chunk = 8,
  parameter int exp   = $clog2(width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_raw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_norm,
  output logic [exp-1:0]   out_shift,
  output logic             out_zero
);

  localparam int nchunk = width / chunk;
  localparam int pw = (nchunk > 1) ? $clog2(nchunk) : 1;
  localparam int lw = (chunk > 1) ? $clog2(chunk) : 1;

  if ((width % chunk) != 0 || chunk < 2) begin : g_bad_params
    $error("svfloat_norm_seq: width must be a multiple of chunk, chunk >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t           state;
  logic [width-1:0] data;
  logic [pw-1:0]    ptr;
  logic [chunk-1:0] cur;
  logic [lw-1:0]    lidx;
  logic [exp-1:0]   idx;
  logic [exp-1:0]   shift;

  assign cur = data[ptr*chunk +: chunk];

  // Single chunk-wide MSB finder; highest set bit wins.
  always_comb begin
    lidx = '0;
    for (int i = 0; i < chunk; i++) begin
      if (cur[i]) lidx = lw'(i);
    end
  end

  assign idx   = exp'(int'(ptr) * chunk + int'(lidx));
  assign shift = exp'(width - 1) - idx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data      <= '0;
      ptr       <= '0;
      out_norm  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= in_raw;
            ptr   <= pw'(nchunk - 1);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (|cur) begin
            out_shift <= shift;
            out_norm  <= data << shift;
            out_zero  <= 1'b0;
            state     <= DONE;
          end else if (ptr != '0) begin
            ptr <= ptr - 1'b1;
          end else begin
            out_shift <= '0;
            out_norm  <= '0;
            out_zero  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svfloat_norm_seq.sv
// Directed and random checks of svfloat_norm_seq (width=32, chunk=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_svfloat_norm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_raw;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_norm;
  logic [4:0]  out_shift;
  logic        out_zero;

  int tests = 0;
  int fails = 0;

  svfloat_norm_seq #(.width(32), .chunk(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_raw    (in_raw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_norm  (out_norm),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Offer v, measure latency, hold the result for `stall` cycles with
  // in_valid toggling junk, then hand it off.
  task automatic op(input logic [31:0] v, input int stall);
    int msb;
    int lat;
    int w;
    int elat;
    logic [31:0] en;
    logic [4:0]  es;
    logic        ez;
    msb = -1;
    for (int i = 0; i < 32; i++) if (v[i]) msb = i;
    if (msb < 0) begin
      ez = 1'b1; es = 5'd0; en = 32'd0; elat = 4;
    end else begin
      ez = 1'b0; es = 5'(31 - msb); en = v << es; elat = 4 - msb / 8;
    end
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_raw   = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_raw   = 32'hDEAD_BEEF;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("out_norm", out_norm, en);
    check("out_shift", 32'(out_shift), 32'(es));
    check("out_zero", 32'(out_zero), 32'(ez));
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    for (int c = 0; c < stall; c++) begin
      in_valid = c[0];
      in_raw   = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_norm", out_norm, en);
      check("hold_shift", 32'(out_shift), 32'(es));
      check("hold_zero", 32'(out_zero), 32'(ez));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_valid", 32'(out_valid), 32'd0);
    check("handoff_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_raw    = 32'd0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_norm", out_norm, 32'd0);
    check("rst_out_shift", 32'(out_shift), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op(32'h8000_0000, 0);
    op(32'h0001_2345, 0);
    op(32'h0000_0001, 1);
    op(32'h0000_0000, 0);
    op(32'h0001_2345, 3);

    // Reset in the middle of scanning 0x1.
    in_valid = 1'b1;
    in_raw   = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midscan_rst_ready", 32'(in_ready), 32'd1);
    check("midscan_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    op(32'h0000_0F00, 0);

    for (int n = 0; n < 24; n++) begin
      r = $urandom;
      r = r >> $urandom_range(0, 32);
      op(r, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/svfloat_norm_seq.md
SVFLOAT_NORM_SEQ -- requirements
Module: svfloat_norm_seq

Interface
REQ-001 SHALL have parameter width, default 32: bit width of the integer/mantissa to normalize.
REQ-002 SHALL have parameter chunk, default 8: bits examined per scan cycle by the internal MSB finder.
REQ-003 SHALL have parameter exp, default $clog2(width): bit width of the shift-amount output.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: an operand is offered on in_raw.
REQ-007 SHALL have port in_ready  output  1: the block can accept an operand.
REQ-008 SHALL have port in_raw  input  width: operand to normalize.
REQ-009 SHALL have port out_valid  output  1: a result is presented.
REQ-010 SHALL have port out_ready  input  1: the consumer accepts the result.
REQ-011 SHALL have port out_norm  output  width: in_raw shifted left so its MSB lands at bit width-1.
REQ-012 SHALL have port out_shift  output  exp: left-shift amount applied, i.e. width-1 minus the MSB index.
REQ-013 SHALL have port out_zero  output  1: the operand was all zeros.

Function
REQ-014 SHALL fail elaboration ($error) if width is not a multiple of chunk, or if chunk < 2.
REQ-015 SHALL implement three states: IDLE, SCAN, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 In IDLE, on a clock edge with in_valid=1, SHALL capture in_raw, set the chunk pointer to the top chunk (width/chunk-1) and enter SCAN.
REQ-018 In SCAN, each cycle SHALL examine the chunk bits [ptr*chunk+chunk-1 : ptr*chunk] with one chunk-wide MSB finder; no other leading-one logic SHALL be instantiated.
REQ-019 If the examined chunk is nonzero, SHALL compute idx = ptr*chunk + local MSB index and register out_shift = width-1-idx, out_norm = captured operand << out_shift and out_zero=0, then enter DONE.
REQ-020 If the examined chunk is zero and ptr>0, SHALL decrement ptr and remain in SCAN.
REQ-021 If the examined chunk is zero and ptr==0, SHALL register out_zero=1, out_shift=0, out_norm=0 and enter DONE.
REQ-022 Latency: out_valid SHALL rise k edges after the accepting edge, where k = number of chunks scanned (1 to width/chunk); the all-zero operand takes width/chunk.
REQ-023 In DONE, outputs SHALL remain stable while out_ready=0; on an edge with out_ready=1, SHALL return to IDLE.
REQ-024 SHALL NOT accept a new operand in the DONE-to-IDLE handoff cycle; in_ready rises the cycle after the output handshake, so the minimum issue interval is k+2 cycles.
REQ-025 in_valid and in_raw SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-026 out_norm, out_shift and out_zero SHALL change only on entry to DONE and on reset.

Reset
REQ-027 On rst=1, SHALL immediately (asynchronously) enter IDLE, with in_ready=1, out_valid=0, out_norm=0, out_shift=0, out_zero=0 and the chunk pointer=0.
REQ-028 Reset asserted during SCAN or DONE SHALL discard the in-flight operand; no out_valid SHALL follow reset release until a new operand is accepted.

Verification (width=32, chunk=8)
REQ-029 in_raw=0x80000000 accepted -> out_valid after 1 edge; out_norm=0x80000000, out_shift=0, out_zero=0.
REQ-030 in_raw=0x00012345 -> out_valid after 2 edges; out_shift=15, out_norm=0x91A28000, out_zero=0.
REQ-031 in_raw=0x00000001 -> out_valid after 4 edges; out_shift=31, out_norm=0x80000000; in_raw=0x00000000 -> after 4 edges out_zero=1, out_shift=0, out_norm=0.
REQ-032 Result held with out_ready=0 for 3 cycles while in_valid toggles with new data -> outputs stable, in_ready=0, no capture; out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-033 rst pulsed mid-SCAN of 0x00000001 -> out_valid stays 0 and in_ready=1 immediately; a following 0x00000F00 yields out_shift=20, out_norm=0xF0000000 after 3 edges.
REQ-034 Back-to-back random operands with random out_ready stalls -> each result matches a reference leading-zero count and shift; the scoreboard checks latency = chunks scanned.
